// File: rtl/mips_defs.sv
// Shared definitions for the register-file write-port arbiter.
// Holds default widths, the write-source encoding and the FSM state type.
package mips_defs;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WSRC_W = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [WSRC_W-1:0] {
        WSRC_NONE = 2'd0,
        WSRC_PIPE = 2'd1,
        WSRC_LU   = 2'd2,
        WSRC_MEM  = 2'd3
    } wsrc_e;

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_STARVING = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[0] wins ties when the pointer is 0,
// req[1] wins ties when the pointer is 1. The pointer toggles on advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_rr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_rr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (advance) begin
            r_rr <= ~r_rr;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline has fixed priority, the long-latency
// unit and late loads share leftover slots round-robin, with a starvation stall.
module rf_wport_arbiter #(
    parameter int unsigned DATA_W       = mips_defs::DATA_W,
    parameter int unsigned ADDR_W       = mips_defs::ADDR_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [1:0]        rf_wsrc,
    output logic              stall_req
);
    import mips_defs::*;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic              w_pipe_eff;
    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_sec_grant;
    logic              w_any_sec;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    wsrc_e             w_wsrc;
    logic [CNT_W-1:0]  w_cnt_nxt;
    state_e            w_state_nxt;

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    wsrc_e             r_wsrc;
    logic [CNT_W-1:0]  r_starve_cnt;
    state_e            r_state;

    // A pipe write to $0 is discarded and leaves the port free for secondaries.
    assign w_pipe_eff  = pipe_we && (pipe_waddr != '0);
    assign w_req       = {mem_valid, lu_valid} & {2{~w_pipe_eff}};
    assign w_sec_grant = |w_grant;
    assign w_any_sec   = lu_valid | mem_valid;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_sec_grant),
        .grant   (w_grant)
    );

    assign lu_ready  = w_grant[0];
    assign mem_ready = w_grant[1];

    // Next write-port contents; a granted secondary to $0 is consumed silently.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        w_wsrc  = WSRC_NONE;
        if (w_pipe_eff) begin
            w_we    = 1'b1;
            w_waddr = pipe_waddr;
            w_wdata = pipe_wdata;
            w_wsrc  = WSRC_PIPE;
        end else if (w_grant[0] && (lu_waddr != '0)) begin
            w_we    = 1'b1;
            w_waddr = lu_waddr;
            w_wdata = lu_wdata;
            w_wsrc  = WSRC_LU;
        end else if (w_grant[1] && (mem_waddr != '0)) begin
            w_we    = 1'b1;
            w_waddr = mem_waddr;
            w_wdata = mem_wdata;
            w_wsrc  = WSRC_MEM;
        end
    end

    // Starvation counter and stall FSM next-state.
    always_comb begin
        w_cnt_nxt   = r_starve_cnt;
        w_state_nxt = r_state;
        if (w_sec_grant || !w_any_sec) begin
            w_cnt_nxt = '0;
        end else if (r_starve_cnt != LIMIT) begin
            w_cnt_nxt = r_starve_cnt + CNT_W'(1);
        end
        case (r_state)
            ST_NORMAL: begin
                // A grant in the same cycle already relieves the starvation.
                if ((r_starve_cnt == LIMIT) && !w_sec_grant) begin
                    w_state_nxt = ST_STARVING;
                end
            end
            ST_STARVING: begin
                if (w_sec_grant) begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            default: w_state_nxt = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_wsrc       <= WSRC_NONE;
            r_starve_cnt <= '0;
            r_state      <= ST_NORMAL;
        end else begin
            r_we         <= w_we;
            r_waddr      <= w_waddr;
            r_wdata      <= w_wdata;
            r_wsrc       <= w_wsrc;
            r_starve_cnt <= w_cnt_nxt;
            r_state      <= w_state_nxt;
        end
    end

    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign rf_wsrc   = r_wsrc;
    assign stall_req = (r_state == ST_STARVING);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with hand-computed expectations.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  rf_wsrc;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_wsrc    (rf_wsrc),
        .stall_req  (stall_req)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic [1:0] src);
        check({tag, ".we"},   32'(rf_we),    32'(we));
        check({tag, ".addr"}, 32'(rf_waddr), 32'(a));
        check({tag, ".data"}, rf_wdata,      d);
        check({tag, ".src"},  32'(rf_wsrc),  32'(src));
    endtask

    task automatic check_rdy(input string tag, input logic lu, input logic mem);
        #1;
        check({tag, ".lu_ready"},  32'(lu_ready),  32'(lu));
        check({tag, ".mem_ready"}, 32'(mem_ready), 32'(mem));
    endtask

    initial begin
        // Reset with every input active.
        rst = 1'b1;
        pipe_we = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'hA5A5_0007;
        lu_valid = 1'b1; lu_waddr = 5'd1; lu_wdata = 32'h1;
        mem_valid = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h2;
        tick(); tick();
        check_wr("reset", 1'b0, 5'd0, 32'h0, 2'd0);
        check("reset.stall", 32'(stall_req), 32'd0);
        check_rdy("reset", 1'b0, 1'b0);

        rst = 1'b0;
        tick();
        check_wr("first_after_reset", 1'b1, 5'd7, 32'hA5A5_0007, 2'd1);
        lu_valid = 1'b0; mem_valid = 1'b0; pipe_we = 1'b0;
        tick();
        check_wr("idle", 1'b0, 5'd0, 32'h0, 2'd0);

        // Pipe only, then pipe to $0.
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEAD_BEEF;
        tick();
        check_wr("pipe_r5", 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1);
        pipe_waddr = 5'd0;
        tick();
        check_wr("pipe_r0", 1'b0, 5'd0, 32'h0, 2'd0);
        pipe_we = 1'b0;

        // lu and mem contend with the pointer at 0.
        lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'h11;
        mem_valid = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'h22;
        check_rdy("cont0", 1'b1, 1'b0);
        tick();
        check_wr("cont_lu", 1'b1, 5'd3, 32'h11, 2'd2);
        lu_valid = 1'b0;
        check_rdy("cont1", 1'b0, 1'b1);
        tick();
        check_wr("cont_mem", 1'b1, 5'd4, 32'h22, 2'd3);
        mem_valid = 1'b0;

        // mem to $0 is consumed without a write; pointer moves 0 -> 1.
        mem_valid = 1'b1; mem_waddr = 5'd0; mem_wdata = 32'h33;
        check_rdy("mem_r0", 1'b0, 1'b1);
        tick();
        check_wr("mem_r0", 1'b0, 5'd0, 32'h0, 2'd0);
        mem_valid = 1'b0;
        lu_valid = 1'b1; mem_valid = 1'b1; mem_waddr = 5'd4;
        check_rdy("rr_after_mem_r0", 1'b0, 1'b1);
        lu_valid = 1'b0; mem_valid = 1'b0;

        // Starvation: pipe every cycle while lu waits.
        pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h99;
        lu_valid = 1'b1; lu_waddr = 5'd6; lu_wdata = 32'h66;
        check_rdy("starve_denied", 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("starve_c%0d.stall", i), 32'(stall_req), 32'd0);
        end
        tick();
        check("starve_c5.stall", 32'(stall_req), 32'd1);
        check_wr("starve_c5", 1'b1, 5'd9, 32'h99, 2'd1);
        tick();
        check("starve_pipe_wins.stall", 32'(stall_req), 32'd1);
        pipe_we = 1'b0;
        check_rdy("starve_release", 1'b1, 1'b0);
        tick();
        check("starve_fall.stall", 32'(stall_req), 32'd0);
        check_wr("starve_lu", 1'b1, 5'd6, 32'h66, 2'd2);
        check("starve_cnt_clear", 32'(dut.r_starve_cnt), 32'd0);
        lu_valid = 1'b0;

        // Pointer back at 0 here; one lu grant moves it to 1.
        lu_valid = 1'b1; lu_waddr = 5'd8; lu_wdata = 32'h88;
        tick();
        check_wr("lu_r8", 1'b1, 5'd8, 32'h88, 2'd2);
        lu_valid = 1'b0;

        // Starve mem, then assert reset between edges.
        pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'hAA;
        mem_valid = 1'b1; mem_waddr = 5'd11; mem_wdata = 32'hBB;
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset.stall", 32'(stall_req), 32'd1);
        check("pre_reset.we", 32'(rf_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset.stall", 32'(stall_req), 32'd0);
        check("async_reset.we", 32'(rf_we), 32'd0);
        tick();
        pipe_we = 1'b0;
        lu_valid = 1'b1; lu_waddr = 5'd12; lu_wdata = 32'hCC;
        rst = 1'b0;
        check_rdy("post_reset_rr0", 1'b1, 1'b0);
        tick();
        check_wr("post_reset_lu", 1'b1, 5'd12, 32'hCC, 2'd2);
        check("post_reset.stall", 32'(stall_req), 32'd0);
        lu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
